// File: rtl/syscall_io_ctrl.sv
// rtl/syscall_io_ctrl.sv - SYSCALL input/output sequencer: PC stall, button debounce, switch capture, display latch
module syscall_io_ctrl #(
    parameter int SW_W       = 16,
    parameter int DEB_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic [31:0]     rs_data,
    input  logic [SW_W-1:0] switches,
    input  logic            btn_enter,
    output logic            pc_stall,
    output logic            io_wr_en,
    output logic [31:0]     io_wr_data,
    output logic [31:0]     disp_value,
    output logic            disp_valid,
    output logic            waiting_input
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [5:0]    OP_IN    = 6'b110011;
    localparam logic [5:0]    OP_OUT   = 6'b110111;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_PRESS = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sync1;
    logic          sync2;
    logic          btn_db;
    logic [CW-1:0] deb_cnt;
    logic          capture;
    logic          disp_load;

    // Counter only advances while the synchronised level disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_enter;
            sync2 <= sync1;
            if (sync2 == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= ~btn_db;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ARM waits for a release so a button still held from the last input is not reused.
    always_comb begin
        state_next = state;
        pc_stall   = 1'b0;
        io_wr_en   = 1'b0;
        capture    = 1'b0;
        disp_load  = 1'b0;
        case (state)
            IDLE: begin
                if (op == OP_IN) begin
                    pc_stall   = 1'b1;
                    state_next = ARM;
                end else if (op == OP_OUT) begin
                    disp_load = 1'b1;
                end
            end
            ARM: begin
                pc_stall = 1'b1;
                if (!btn_db) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                pc_stall = 1'b1;
                if (btn_db) begin
                    capture    = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                io_wr_en   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_wr_data <= '0;
            disp_value <= '0;
            disp_valid <= 1'b0;
        end else begin
            if (capture) begin
                io_wr_data <= 32'(switches);
            end
            if (disp_load) begin
                disp_value <= rs_data;
                disp_valid <= 1'b1;
            end
        end
    end

    assign waiting_input = pc_stall;

endmodule

// File: tb/tb_syscall_io_ctrl.sv
// tb/tb_syscall_io_ctrl.sv - self-checking bench for syscall_io_ctrl against a behavioural model
module tb_syscall_io_ctrl;

    localparam int         D      = 4;
    localparam logic [5:0] OP_IN  = 6'b110011;
    localparam logic [5:0] OP_OUT = 6'b110111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [31:0] rs_data = 32'd0;
    logic [15:0] switches = 16'd0;
    logic        btn_enter = 1'b0;
    logic        pc_stall;
    logic        io_wr_en;
    logic [31:0] io_wr_data;
    logic [31:0] disp_value;
    logic        disp_valid;
    logic        waiting_input;

    syscall_io_ctrl #(.SW_W(16), .DEB_CYCLES(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .rs_data(rs_data),
        .switches(switches),
        .btn_enter(btn_enter),
        .pc_stall(pc_stall),
        .io_wr_en(io_wr_en),
        .io_wr_data(io_wr_data),
        .disp_value(disp_value),
        .disp_valid(disp_valid),
        .waiting_input(waiting_input)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the button is accepted once the synchronised level has
    // disagreed with the accepted level for D consecutive edges.
    bit          m_s1, m_s2, m_db;
    bit          hist[$];
    bit          m_busy, m_released, m_commit;
    logic [31:0] m_data, m_disp;
    bit          m_dvalid;
    bit          pre_db, all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; hist.delete();
            m_busy = 0; m_released = 0; m_commit = 0;
            m_data = 32'd0; m_disp = 32'd0; m_dvalid = 0;
        end else begin
            pre_db = m_db;
            if (m_commit) begin
                m_commit = 0;
            end else if (m_busy) begin
                if (!m_released) begin
                    if (!pre_db) m_released = 1;
                end else if (pre_db) begin
                    m_commit = 1;
                    m_busy   = 0;
                    m_data   = {16'h0000, switches};
                end
            end else if (op == OP_IN) begin
                m_busy = 1;
                m_released = 0;
            end else if (op == OP_OUT) begin
                m_disp = rs_data;
                m_dvalid = 1;
            end
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                all_diff = 1;
                foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
                if (all_diff) begin
                    m_db = ~m_db;
                    hist.delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_enter;
        end
    end

    logic exp_stall;
    always @(negedge clk) begin
        exp_stall = m_busy || (!m_commit && op == OP_IN);
        chk("pc_stall", {31'd0, pc_stall}, {31'd0, exp_stall});
        chk("waiting_input", {31'd0, waiting_input}, {31'd0, exp_stall});
        chk("io_wr_en", {31'd0, io_wr_en}, {31'd0, m_commit});
        chk("io_wr_data", io_wr_data, m_data);
        chk("disp_value", disp_value, m_disp);
        chk("disp_valid", {31'd0, disp_valid}, {31'd0, m_dvalid});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic window(input int n, output int s, output int stalls, output int first_cyc,
                          output logic [31:0] first_data, output logic first_stall);
        s = 0; stalls = 0; first_cyc = -1; first_data = 32'd0; first_stall = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (pc_stall) stalls++;
            if (io_wr_en) begin
                if (s == 0) begin
                    first_cyc   = cyc;
                    first_data  = io_wr_data;
                    first_stall = pc_stall;
                end
                s++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    int          s, st, fc, e, acc_s, acc_st;
    logic [31:0] fd;
    logic        fs;
    int          op_hold, btn_hold;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        window(10, s, st, fc, fd, fs);
        chk("rst_strobes", s, 0);
        chk("rst_stalls", st, 0);
        @(negedge clk);
        chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
        chk("rst_wr_data", io_wr_data, 32'd0);
        tick(1);

        op = OP_OUT; rs_data = 32'h12345678;
        window(1, s, st, fc, fd, fs);
        chk("out_stall", st, 0);
        op = 6'd0; rs_data = 32'hDEADBEEF;
        window(3, s, st, fc, fd, fs);
        chk("out_disp_value", disp_value, 32'h12345678);
        chk("out_disp_valid", {31'd0, disp_valid}, 32'd1);

        op = OP_IN; switches = 16'h00A5; btn_enter = 1'b0;
        @(negedge clk);
        chk("in_first_stall", {31'd0, pc_stall}, 32'd1);
        tick(1);
        window(3, s, st, fc, fd, fs);
        btn_enter = 1'b1; e = cyc;
        window(20, s, st, fc, fd, fs);
        chk("in_strobe_count", s, 1);
        chk("in_strobe_cycle", fc, e + 7);
        chk("in_wr_data", fd, 32'h000000A5);
        chk("in_commit_stall", {31'd0, fs}, 32'd0);

        switches = 16'hBEEF;
        window(10, s, st, fc, fd, fs);
        chk("held_no_strobe", s, 0);
        chk("held_stalls", st, 10);
        btn_enter = 1'b0;
        window(8, s, st, fc, fd, fs);
        chk("release_no_strobe", s, 0);
        btn_enter = 1'b1; e = cyc;
        window(20, s, st, fc, fd, fs);
        chk("repress_strobe_count", s, 1);
        chk("repress_strobe_cycle", fc, e + 7);
        chk("repress_wr_data", fd, 32'h0000BEEF);

        btn_enter = 1'b0;
        window(10, s, st, fc, fd, fs);
        acc_s = 0; acc_st = 0;
        for (int i = 0; i < 20; i++) begin
            btn_enter = ~btn_enter;
            window(2, s, st, fc, fd, fs);
            acc_s += s;
            acc_st += st;
        end
        chk("bounce_no_strobe", acc_s, 0);
        chk("bounce_stalls", acc_st, 40);

        btn_enter = 1'b1;
        window(3, s, st, fc, fd, fs);
        rst_n = 1'b0;
        window(2, s, st, fc, fd, fs);
        acc_s = s;
        rst_n = 1'b1; op = 6'd0; btn_enter = 1'b0;
        window(10, s, st, fc, fd, fs);
        chk("midrst_no_strobe", acc_s + s, 0);
        chk("midrst_disp_value", disp_value, 32'd0);
        chk("midrst_disp_valid", {31'd0, disp_valid}, 32'd0);
        chk("midrst_wr_data", io_wr_data, 32'd0);

        op_hold = 0; btn_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (op_hold == 0) begin
                case ($urandom % 4)
                    0: op = OP_IN;
                    1: op = OP_OUT;
                    2: op = 6'd0;
                    default: op = 6'($urandom % 64);
                endcase
                op_hold = $urandom_range(1, 6);
            end
            op_hold--;
            if (btn_hold == 0) begin
                btn_enter = ~btn_enter;
                btn_hold = $urandom_range(1, 12);
            end
            btn_hold--;
            rs_data = $urandom;
            if ($urandom % 8 == 0) switches = 16'($urandom);
            rst_n = ($urandom % 600 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
